// File: rtl/bottleneck_n.sv
// bottleneck_n: registered adapter from the 64-bit CPU data port to an SW-bit slave bus.
// Each master request becomes little-endian slave beats; read data is reassembled and extended.
module bottleneck_n #(
  parameter int SW = 16,
  parameter int AW = 64
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [AW-1:0] m_adr_i,
  input  logic          m_cyc_i,
  input  logic          m_stb_i,
  input  logic          m_we_i,
  input  logic [1:0]    m_siz_i,
  input  logic          m_signed_i,
  input  logic [63:0]   m_dat_i,
  output logic          m_ack_o,
  output logic [63:0]   m_dat_o,
  output logic          m_err_align_o,
  output logic [AW-1:0] s_adr_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [1:0]    s_siz_o,
  output logic          s_signed_o,
  output logic [SW-1:0] s_dat_o,
  input  logic          s_ack_i,
  input  logic [SW-1:0] s_dat_i
);

  localparam int LSW = (SW == 8) ? 0 : (SW == 16) ? 1 : 2;

  generate
    if (SW != 8 && SW != 16 && SW != 32) begin : g_bad_sw
      $error("bottleneck_n: SW must be 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [2:0]    beat;
  logic [AW-1:0] adr_q;
  logic [1:0]    siz_q;
  logic          we_q;
  logic          signed_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rbuf;

  logic          misaligned;
  logic [2:0]    align_mask;
  logic [2:0]    last_idx;
  logic [5:0]    bit_off;
  logic [1:0]    beat_siz;
  logic [SW-1:0] beat_wdata;
  logic [SW-1:0] wmask;
  logic [63:0]   read_result;

  // Index of the final beat: max(1, bytes >> LSW) - 1.
  function automatic logic [2:0] last_beat_idx(input logic [1:0] siz);
    logic [3:0] n;
    n = 4'd1 << siz;
    n = n >> LSW;
    return (n == 4'd0) ? 3'd0 : 3'(n - 4'd1);
  endfunction

  always_comb begin
    align_mask = 3'b000;
    case (m_siz_i)
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      2'd3:    align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
    misaligned = |(m_adr_i[2:0] & align_mask);
    last_idx   = last_beat_idx(siz_q);
    beat_siz   = (siz_q > 2'(LSW)) ? 2'(LSW) : siz_q;
    bit_off    = 6'(beat) * 6'(SW);
    wmask      = '1;
    if (beat_siz == 2'd0)
      wmask = SW'(8'hFF);
    else if (beat_siz == 2'd1)
      wmask = SW'(16'hFFFF);
    beat_wdata = SW'(wdata_q >> bit_off) & wmask;
  end

  // Truncate the reassembled buffer to the request size, then sign- or zero-extend.
  always_comb begin
    case (siz_q)
      2'd0:    read_result = {{56{signed_q & rbuf[7]}},  rbuf[7:0]};
      2'd1:    read_result = {{48{signed_q & rbuf[15]}}, rbuf[15:0]};
      2'd2:    read_result = {{32{signed_q & rbuf[31]}}, rbuf[31:0]};
      default: read_result = rbuf;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_ack_o       = 1'b0;
    m_err_align_o = 1'b0;
    m_dat_o       = '0;
    s_adr_o       = '0;
    s_cyc_o       = 1'b0;
    s_stb_o       = 1'b0;
    s_we_o        = 1'b0;
    s_siz_o       = 2'd0;
    s_signed_o    = 1'b0;
    s_dat_o       = '0;
    case (state)
      IDLE: begin
        if (m_cyc_i && m_stb_i)
          state_nxt = misaligned ? ERR : XFER;
      end
      XFER: begin
        s_cyc_o    = 1'b1;
        s_stb_o    = 1'b1;
        s_we_o     = we_q;
        s_signed_o = signed_q;
        s_siz_o    = beat_siz;
        s_adr_o    = adr_q + (AW'(beat) << LSW);
        s_dat_o    = beat_wdata;
        // Dropping m_cyc_i abandons the transfer; a coincident slave ack is discarded.
        if (!m_cyc_i)
          state_nxt = IDLE;
        else if (s_ack_i && beat == last_idx)
          state_nxt = DONE;
      end
      DONE: begin
        m_ack_o   = 1'b1;
        m_dat_o   = we_q ? 64'd0 : read_result;
        state_nxt = IDLE;
      end
      ERR: begin
        m_err_align_o = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      beat     <= 3'd0;
      adr_q    <= '0;
      siz_q    <= 2'd0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= 64'd0;
      rbuf     <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i && !misaligned) begin
            adr_q    <= m_adr_i;
            siz_q    <= m_siz_i;
            we_q     <= m_we_i;
            signed_q <= m_signed_i;
            wdata_q  <= m_dat_i;
            rbuf     <= 64'd0;
            beat     <= 3'd0;
          end
        end
        XFER: begin
          if (m_cyc_i && s_ack_i) begin
            rbuf <= (rbuf & ~(64'({SW{1'b1}}) << bit_off)) | (64'(s_dat_i) << bit_off);
            if (beat != last_idx)
              beat <= beat + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
